dmem_responder: RTL and testbench

- Memory-stage data-memory responder with multi-cycle latency.
- Answers the load/store requests that the execute-to-memory pipeline register drives: aluoutM is the address, writedataM the store data, memWriteM and memtoRegM the request type.
- Holds the pipeline with stallM until the access completes, then returns readdataM to the memory-to-writeback register.
- Replaces the single-cycle combinational data memory so the pipeline can be tested against a slow memory model.

---
 rtl/dmem_responder_pkg.sv | 21 ++
 rtl/dmem_responder_array.sv | 25 ++
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte address bits below the word index.
  localparam int ADDR_LSB = 2;

  // Ceiling log2 with a minimum of one bit, so degenerate sizes still give a legal vector.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word array: synchronous write, combinational read of the pre-write contents.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [clog2_min1(DEPTH)-1:0] idx,
  input  logic [WIDTH-1:0]             wd,
  output logic [WIDTH-1:0]             rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The read port sees the old word during the write edge, giving read-before-write.
  assign rd = mem[idx];

  // Commit a store on the clock edge; the contents have no reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: stalls the pipeline for WAIT_CYCLES+1 cycles per access,
// then completes the load/store in a one-cycle RESP state.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memReadM,
  input  logic             memWriteM,
  input  logic [WIDTH-1:0] addrM,
  input  logic [WIDTH-1:0] writedataM,
  output logic [WIDTH-1:0] readdataM,
  output logic             stallM,
  output logic             respValid,
  output logic             busy
);

  localparam int IDX_W = clog2_min1(DEPTH);
  localparam int CNT_W = clog2_min1(WAIT_CYCLES + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q, addr_idx, acc_idx;
  logic [WIDTH-1:0] wd_q, acc_wd, arr_rd;
  logic             rd_q, wr_q, acc_rd, acc_wr;
  logic             req, commit, arr_we;
  logic             unused_addr;

  assign req      = memReadM | memWriteM;
  assign addr_idx = addrM[ADDR_LSB +: IDX_W];

  // Byte offset and high address bits are dropped: word access, address wraps.
  assign unused_addr = ^{addrM[ADDR_LSB-1:0], addrM[WIDTH-1:ADDR_LSB+IDX_W]};

  // With zero wait states the commit happens on the accepting edge, before the
  // request is latched, so the array is fed directly from the live inputs in IDLE.
  assign acc_idx = (state == ST_IDLE) ? addr_idx   : idx_q;
  assign acc_wd  = (state == ST_IDLE) ? writedataM : wd_q;
  assign acc_rd  = (state == ST_IDLE) ? memReadM   : rd_q;
  assign acc_wr  = (state == ST_IDLE) ? memWriteM  : wr_q;

  assign commit = (state_nxt == ST_RESP) && (state != ST_RESP);
  assign arr_we = commit & acc_wr;

  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk (clk),
    .we  (arr_we),
    .idx (acc_idx),
    .wd  (acc_wd),
    .rd  (arr_rd)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and pipeline handshake outputs.
  always_comb begin
    state_nxt = state;
    stallM    = 1'b0;
    respValid = 1'b0;
    busy      = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          stallM    = 1'b1;
          state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        stallM = 1'b1;
        if (cnt == '0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        respValid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, wait-state down-counter and registered load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      idx_q     <= '0;
      wd_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      readdataM <= '0;
    end else begin
      if (state == ST_IDLE && req) begin
        idx_q <= addr_idx;
        wd_q  <= writedataM;
        rd_q  <= memReadM;
        wr_q  <= memWriteM;
        cnt   <= (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit && acc_rd) readdataM <= arr_rd;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        memReadM = 1'b0, memWriteM = 1'b0;
  logic [31:0] addrM = '0, writedataM = '0, readdataM;
  logic        stallM, respValid, busy;

  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
  logic        stall0, resp0, busy0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WIDTH(32), .DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .memReadM(memReadM), .memWriteM(memWriteM),
    .addrM(addrM), .writedataM(writedataM), .readdataM(readdataM),
    .stallM(stallM), .respValid(respValid), .busy(busy)
  );

  dmem_responder #(.WIDTH(32), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .memReadM(rd0), .memWriteM(wr0),
    .addrM(addr0), .writedataM(wdata0), .readdataM(rdata0),
    .stallM(stall0), .respValid(resp0), .busy(busy0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Presents one request, counts stall cycles, checks the response pulse, and
  // returns with the FSM back in IDLE and the inputs cleared.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int stalls, output logic [31:0] rdata);
    memReadM = r; memWriteM = w; addrM = a; writedataM = d;
    #1;
    chk("accept_idle", {31'b0, busy}, 32'd0);
    stalls = 0;
    while (stallM === 1'b1 && stalls < 20) begin
      stalls++;
      tick();
    end
    chk("resp_pulse", {31'b0, respValid}, 32'd1);
    rdata = readdataM;
    tick();
    memReadM = 1'b0; memWriteM = 1'b0; addrM = '0; writedataM = '0;
  endtask

  initial begin : timeout
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    int          st;
    logic [31:0] rv;

    #12 reset = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_rdata", readdataM, 32'd0);
      chk("idle_stall", {31'b0, stallM}, 32'd0);
      chk("idle_resp",  {31'b0, respValid}, 32'd0);
      chk("idle_busy",  {31'b0, busy}, 32'd0);
    end

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, st, rv);
    chk("store_stalls", st, 32'd3);
    chk("store_keeps_rdata", rv, 32'd0);
    tick();
    access(1'b1, 1'b0, 32'h10, 32'h0, st, rv);
    chk("load_stalls", st, 32'd3);
    chk("load_data", rv, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'h20, 32'h11111111, st, rv);
    access(1'b1, 1'b0, 32'h20, 32'h0, st, rv);
    chk("b2b_stalls", st, 32'd3);
    chk("b2b_data", rv, 32'h11111111);

    access(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, st, rv);
    access(1'b1, 1'b1, 32'h30, 32'h5A5A5A5A, st, rv);
    chk("rw_old_data", rv, 32'hA5A5A5A5);
    access(1'b1, 1'b0, 32'h30, 32'h0, st, rv);
    chk("rw_new_data", rv, 32'h5A5A5A5A);

    access(1'b0, 1'b1, 32'h103, 32'h12345678, st, rv);
    access(1'b1, 1'b0, 32'h000, 32'h0, st, rv);
    chk("wrap_data", rv, 32'h12345678);

    access(1'b0, 1'b1, 32'h40, 32'h0, st, rv);
    memWriteM = 1'b1; addrM = 32'h40; writedataM = 32'hCAFEF00D;
    tick();
    chk("pre_reset_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    memWriteM = 1'b0; addrM = '0; writedataM = '0;
    #2;
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stallM}, 32'd0);
    chk("rst_resp",  {31'b0, respValid}, 32'd0);
    chk("rst_rdata", readdataM, 32'd0);
    reset = 1'b1;
    tick();
    access(1'b1, 1'b0, 32'h40, 32'h0, st, rv);
    chk("rst_store_dropped", rv, 32'h0);

    wr0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h77;
    #1;
    chk("w0_store_stall", {31'b0, stall0}, 32'd1);
    tick();
    chk("w0_store_unstall", {31'b0, stall0}, 32'd0);
    chk("w0_store_resp",    {31'b0, resp0}, 32'd1);
    wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    tick();
    rd0 = 1'b1; addr0 = 32'h8;
    #1;
    chk("w0_load_stall", {31'b0, stall0}, 32'd1);
    tick();
    chk("w0_load_unstall", {31'b0, stall0}, 32'd0);
    chk("w0_load_resp",    {31'b0, resp0}, 32'd1);
    chk("w0_load_data",    rdata0, 32'h77);
    rd0 = 1'b0; addr0 = '0;
    tick();
    chk("w0_idle_resp", {31'b0, resp0}, 32'd0);
    chk("w0_idle_busy", {31'b0, busy0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
